// File: rtl/vcxo_lock_sequencer.sv
// vcxo_lock_sequencer: VCXO disciplining loop sequencer.
// Requests gate windows, steers the PWM setpoint and tracks lock/holdover.
module vcxo_lock_sequencer #(
  parameter int unsigned PWM_INIT      = 30000,
  parameter int unsigned PWM_MAX       = 60000,
  parameter int unsigned COARSE_THRESH = 10,
  parameter int unsigned LOCK_COUNT    = 10,
  parameter int unsigned UNLOCK_THRESH = 4,
  parameter int unsigned TIMEOUT_CYC   = 2000000
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable,
  input  logic [31:0] freq_error_in,
  input  logic        meas_valid,
  output logic        meas_start,
  output logic [15:0] pwm_out,
  output logic        pwm_valid,
  output logic [31:0] freq_error_out,
  output logic [1:0]  mode,
  output logic        locked,
  output logic        holdover
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;

  localparam logic [1:0] M_COARSE = 2'd0;
  localparam logic [1:0] M_FINE   = 2'd1;
  localparam logic [1:0] M_LOCKED = 2'd2;

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [32:0]   C_TH      = 33'(COARSE_THRESH);
  localparam logic [32:0]   U_TH      = 33'(UNLOCK_THRESH);

  localparam logic signed [33:0] PWM_LO = 34'sd1;
  localparam logic signed [33:0] PWM_HI = 34'(PWM_MAX - 1);

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [31:0]        err_q, err_d;
  logic signed [33:0] pnew_q, pnew_d;
  logic [15:0]        pwm_q, pwm_d;
  logic               pvld_q, pvld_d;
  logic [31:0]        ferr_q, ferr_d;
  logic [1:0]         mode_q, mode_d;
  logic               lock_q, lock_d;
  logic               hold_q, hold_d;
  logic [CW-1:0]      zcnt_q, zcnt_d;

  logic signed [32:0] err_x;
  logic [32:0]        err_abs;
  logic signed [33:0] pwm_x;
  logic signed [33:0] err_w;
  logic signed [33:0] pwm_prop;
  logic signed [33:0] pwm_step;
  logic               err_zero;
  logic               err_neg;
  logic               unlock;
  logic [15:0]        pwm_c;

  assign err_x    = $signed({err_q[31], err_q});
  assign err_abs  = err_x[32] ? 33'(-err_x) : 33'(err_x);
  assign err_zero = (err_q == 32'd0);
  assign err_neg  = err_q[31];

  assign pwm_x    = $signed({18'd0, pwm_q});
  assign err_w    = $signed({{2{err_q[31]}}, err_q});
  assign pwm_prop = pwm_x - err_w;
  assign pwm_step = err_zero ? pwm_x :
                    err_neg  ? pwm_x + 34'sd1 :
                               pwm_x - 34'sd1;

  assign unlock = (mode_q != M_COARSE) && (err_abs > U_TH);

  assign pwm_c = (pnew_q < PWM_LO) ? 16'd1 :
                 (pnew_q > PWM_HI) ? PWM_HI[15:0] :
                                     pnew_q[15:0];

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pnew_d  = pnew_q;
    pwm_d   = pwm_q;
    pvld_d  = 1'b0;
    ferr_d  = ferr_q;
    mode_d  = mode_q;
    lock_d  = lock_q;
    hold_d  = hold_q;
    zcnt_d  = zcnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      hold_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (meas_valid) begin
            err_d   = freq_error_in;
            hold_d  = 1'b0;
            state_d = S_CALC;
          end else if (tmo_q == TMO_LAST) begin
            hold_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_CALC: begin
          ferr_d  = err_q;
          state_d = S_APPLY;
          // losing lock re-acquires with a full proportional step
          unique case (1'b1)
            unlock: begin
              mode_d = M_COARSE;
              zcnt_d = '0;
              pnew_d = pwm_prop;
            end
            (mode_q == M_COARSE): begin
              pnew_d = (err_abs > C_TH) ? pwm_prop : pwm_step;
              if (!err_zero) begin
                zcnt_d = '0;
              end else if (zcnt_q == LOCK_LAST) begin
                mode_d = M_FINE;
                zcnt_d = '0;
              end else begin
                zcnt_d = zcnt_q + CW'(1);
              end
            end
            (!unlock && mode_q == M_FINE): begin
              pnew_d = pwm_step;
              if (err_abs > 33'd1) begin
                zcnt_d = '0;
              end else if (zcnt_q == LOCK_LAST) begin
                mode_d = M_LOCKED;
                zcnt_d = '0;
              end else begin
                zcnt_d = zcnt_q + CW'(1);
              end
            end
            default: pnew_d = pwm_step;
          endcase
          lock_d = (mode_d == M_LOCKED);
        end
        S_APPLY: begin
          if (pwm_c != pwm_q) begin
            pwm_d  = pwm_c;
            pvld_d = 1'b1;
          end
          state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      err_q   <= '0;
      pnew_q  <= '0;
      pwm_q   <= 16'(PWM_INIT);
      pvld_q  <= 1'b0;
      ferr_q  <= '0;
      mode_q  <= M_COARSE;
      lock_q  <= 1'b0;
      hold_q  <= 1'b0;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      pnew_q  <= pnew_d;
      pwm_q   <= pwm_d;
      pvld_q  <= pvld_d;
      ferr_q  <= ferr_d;
      mode_q  <= mode_d;
      lock_q  <= lock_d;
      hold_q  <= hold_d;
      zcnt_q  <= zcnt_d;
    end
  end

  assign meas_start     = (state_q == S_REQ);
  assign pwm_out        = pwm_q;
  assign pwm_valid      = pvld_q;
  assign freq_error_out = ferr_q;
  assign mode           = mode_q;
  assign locked         = lock_q;
  assign holdover       = hold_q;

endmodule
